prog_delay_line: RTL and testbench
==================================

# prog_delay_line

Clocked, parametrised multi-channel delay line: each of NCH independent channels re-emits its WIDTH-bit valid/data stream exactly D cycles later, with D programmable per channel at run time (1..DEPTH). It is the synchronous, reconfigurable counterpart of the fixed delay-cell chains used to match bundled-data paths. It sits between the clocked test/control domain and the async pipeline stages, where it provides cycle-accurate, retunable matched delays. Reconfiguration flushes the channel so stale samples are never emitted.

## Interface
- WIDTH, 8, data bits per channel
- NCH, 4, number of channels
- DEPTH, 16, maximum delay in cycles (≥2)
- RST_DELAY, 4, per-channel delay loaded at reset (1..DEPTH)
- DW, derived, $clog2(DEPTH+1), delay field width

- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  NCH  per-channel input valid
- in_data  in  NCH*WIDTH  channel c at [c*WIDTH +: WIDTH]
- out_valid  out  NCH  per-channel delayed valid, registered
- out_data  out  NCH*WIDTH  delayed data, registered, same packing
- cfg_we  in  1  write delay for channel cfg_ch
- cfg_ch  in  $clog2(NCH)  target channel; values ≥NCH ignored and flagged
- cfg_delay  in  DW  requested delay in cycles
- cfg_err  out  1  one-cycle pulse: cfg_delay clamped or cfg_ch out of range
- busy  out  NCH  channel settling after reconfiguration

## Operation
- Per channel: ring buffer of {valid,data}, current delay register D, settle counter, 2-state FSM RUN/SETTLE.
- Sample with in_valid=1 at edge k appears on out_valid/out_data after edge k+D; gaps are preserved exactly (in_valid=0 slots emit out_valid=0).
- out_data when out_valid=0: holds last value; not checked.
- cfg_we at edge k, cfg_ch<NCH: D ← clamp(cfg_delay); all in-flight samples of that channel are invalidated; FSM → SETTLE, counter ← new D. Other channels unaffected.
- Clamp: cfg_delay=0 → 1, cfg_delay>DEPTH → DEPTH; either asserts cfg_err after edge k. cfg_ch≥NCH: no state change, cfg_err asserted.
- Sample presented at the same edge k as the cfg write is kept and uses the new D.
- SETTLE: counter decrements each edge; busy=1; out_valid forced 0; at counter reaching 1 → RUN at the edge where the first post-cfg sample can emerge.
- cfg_we to a channel already in SETTLE restarts the flush with the new D.
- Reprogramming with D equal to the current value still flushes.

## Timing
- Reset (rstn low, async): out_valid=0, out_data=0, busy=0, cfg_err=0, all D=RST_DELAY, all ring valid bits 0, FSM=RUN, write pointer=0.
- Reset release: first sample accepted at first rising edge with rstn high.
- Latency: exactly D edges, D∈[1,DEPTH]; D=1 is a single register stage.
- Throughput: one sample per channel per cycle, no backpressure.
- Write pointer wraps modulo DEPTH; read index (wp−D) mod DEPTH, no bubble at wrap.
- cfg effect: visible on busy and cfg_err after edge k; out_valid low for the D cycles following edge k.
- Reset mid-operation discards all in-flight data and programmed delays.

## Structure
- Package prog_delay_pkg: state enum (RUN, SETTLE), clamp_delay function, DW/pointer-width helper localparams.
- Sub-module delay_chan: one channel (ring buffer, D register, settle FSM, output register), instantiated NCH times; top holds shared write pointer, cfg decode, cfg_err.

## Test plan
- Reset then D=4 on ch0, in_valid=1 with data 0x01..0x08 on consecutive edges -> out 0x01..0x08 on consecutive cycles starting 4 edges after first input.
- Ch1 D=16, sparse input (valid every 3rd cycle, data 0xA0+n) over 40 cycles crossing pointer wrap -> identical pattern 16 cycles later, no extra/missing valids.
- Ch2 streaming with D=4, cfg_we ch2 D=2 mid-stream -> in-flight samples dropped, busy=1 and out_valid=0 for 2 cycles, then samples from the cfg edge onward with latency 2; ch0/ch1/ch3 outputs unchanged.
- cfg_delay=0 then cfg_delay=20 (DEPTH=16), and cfg_ch=5 (NCH=4) -> D=1, D=16, no change respectively; cfg_err pulse on each.
- cfg_we on ch3 on two consecutive edges (D=8 then D=3) -> settle restarts, busy clears after 3 cycles.
- rstn low mid-stream for 1 cycle (asynchronous, between edges) -> all outputs 0 immediately, D back to RST_DELAY, no pre-reset sample ever emitted.

Source files
------------

// File: rtl/prog_delay_pkg.sv
// Shared types and helpers for the programmable multi-channel delay line.
package prog_delay_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        SETTLE = 1'b1
    } chan_state_t;

    function automatic int dly_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Requested delays are forced into the legal range 1..depth.
    function automatic int clamp_delay(input int req, input int depth);
        if (req < 1)
            return 1;
        if (req > depth)
            return depth;
        return req;
    endfunction

endpackage

// File: rtl/prog_delay_line_chan.sv
// One delay channel: ring buffer of {valid,data}, programmable delay and a
// RUN/SETTLE flush FSM driving a registered output.
module delay_chan
    import prog_delay_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int RST_DELAY = 4,
    parameter int DW        = 5,
    parameter int PW        = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [PW-1:0]    wp,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             cfg_hit,
    input  logic [DW-1:0]    cfg_delay,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    logic [DEPTH-1:0] vmem;
    logic [WIDTH-1:0] dmem [DEPTH];
    logic [DW-1:0]    dly;
    logic [DW-1:0]    cnt, cnt_nx;
    chan_state_t      state, state_nx;
    int               rd_i;
    logic [PW-1:0]    rd_idx;
    logic             rd_valid;

    // Read slot is (wp - D) mod DEPTH; D == DEPTH reads the slot being overwritten.
    always_comb begin
        rd_i = 0;
        if (int'(wp) >= int'(dly))
            rd_i = int'(wp) - int'(dly);
        else
            rd_i = int'(wp) + DEPTH - int'(dly);
    end
    assign rd_idx   = PW'(rd_i);
    assign rd_valid = vmem[rd_idx] && (state_nx == RUN);

    always_ff @(posedge clk) begin
        dmem[wp] <= in_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vmem      <= '0;
            dly       <= DW'(RST_DELAY);
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            // A reconfiguration drops everything in flight but keeps the
            // sample arriving on the same edge.
            if (cfg_hit)
                vmem <= '0;
            vmem[wp] <= in_valid;
            if (cfg_hit)
                dly <= cfg_delay;
            out_valid <= rd_valid;
            if (rd_valid)
                out_data <= dmem[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (cfg_hit) begin
            state_nx = SETTLE;
            cnt_nx   = cfg_delay;
        end else if (state == SETTLE) begin
            if (cnt <= DW'(1))
                state_nx = RUN;
            else
                cnt_nx = cnt - 1'b1;
        end
    end

    always_comb begin
        busy = (state == SETTLE);
    end

endmodule

// File: rtl/prog_delay_line.sv
// Multi-channel programmable delay line: shared write pointer, config decode
// and error flag around NCH independent delay channels.
module prog_delay_line
    import prog_delay_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NCH       = 4,
    parameter int DEPTH     = 16,
    parameter int RST_DELAY = 4,
    parameter int DW        = dly_width(DEPTH),
    parameter int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       out_valid,
    output logic [NCH*WIDTH-1:0] out_data,
    input  logic                 cfg_we,
    input  logic [CW-1:0]        cfg_ch,
    input  logic [DW-1:0]        cfg_delay,
    output logic                 cfg_err,
    output logic [NCH-1:0]       busy
);

    localparam int PW = ptr_width(DEPTH);

    logic [PW-1:0]  wp;
    logic [NCH-1:0] cfg_hit;
    logic           ch_bad, dly_bad;
    logic [DW-1:0]  cfg_dly_c;

    assign ch_bad    = int'(cfg_ch) >= NCH;
    assign dly_bad   = (cfg_delay == '0) || (int'(cfg_delay) > DEPTH);
    assign cfg_dly_c = DW'(clamp_delay(int'(cfg_delay), DEPTH));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp      <= '0;
            cfg_err <= 1'b0;
        end else begin
            wp      <= (int'(wp) == DEPTH - 1) ? '0 : wp + 1'b1;
            cfg_err <= cfg_we && (ch_bad || dly_bad);
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        assign cfg_hit[c] = cfg_we && (int'(cfg_ch) == c);

        delay_chan #(
            .WIDTH     (WIDTH),
            .DEPTH     (DEPTH),
            .RST_DELAY (RST_DELAY),
            .DW        (DW),
            .PW        (PW)
        ) u_chan (
            .clk       (clk),
            .rstn      (rstn),
            .wp        (wp),
            .in_valid  (in_valid[c]),
            .in_data   (in_data[c*WIDTH +: WIDTH]),
            .cfg_hit   (cfg_hit[c]),
            .cfg_delay (cfg_dly_c),
            .out_valid (out_valid[c]),
            .out_data  (out_data[c*WIDTH +: WIDTH]),
            .busy      (busy[c])
        );
    end

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed bench for prog_delay_line: latency, sparse wrap, reconfiguration,
// clamping, settle restart and asynchronous reset.
module tb_prog_delay_line;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int DEPTH = 16;
    localparam int DW    = 5;
    localparam int CW    = 2;

    // Second instance with a non power-of-two channel count to reach cfg_ch >= NCH.
    localparam int NCH2   = 3;
    localparam int DEPTH2 = 4;
    localparam int DW2    = 3;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       out_valid;
    logic [NCH*WIDTH-1:0] out_data;
    logic                 cfg_we;
    logic [CW-1:0]        cfg_ch;
    logic [DW-1:0]        cfg_delay;
    logic                 cfg_err;
    logic [NCH-1:0]       busy;

    logic [NCH2-1:0]       in_valid2;
    logic [NCH2*WIDTH-1:0] in_data2;
    logic [NCH2-1:0]       out_valid2;
    logic [NCH2*WIDTH-1:0] out_data2;
    logic                  cfg_we2;
    logic [1:0]            cfg_ch2;
    logic [DW2-1:0]        cfg_delay2;
    logic                  cfg_err2;
    logic [NCH2-1:0]       busy2;

    int n_cmp = 0;
    int n_err = 0;

    prog_delay_line #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .RST_DELAY(4)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .cfg_err(cfg_err), .busy(busy)
    );

    prog_delay_line #(.WIDTH(WIDTH), .NCH(NCH2), .DEPTH(DEPTH2), .RST_DELAY(2)) dut2 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid2), .in_data(in_data2),
        .out_valid(out_valid2), .out_data(out_data2), .cfg_we(cfg_we2),
        .cfg_ch(cfg_ch2), .cfg_delay(cfg_delay2), .cfg_err(cfg_err2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input int c, input logic v, input logic [7:0] d);
        in_valid[c]          = v;
        in_data[c*WIDTH +: 8] = d;
    endtask

    function automatic logic [31:0] od(input int c);
        return 32'(out_data[c*WIDTH +: 8]);
    endfunction

    initial begin
        int  s;
        logic ev;

        rstn = 1'b0; in_valid = '0; in_data = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_delay = '0;
        in_valid2 = '0; in_data2 = '0; cfg_we2 = 1'b0; cfg_ch2 = '0; cfg_delay2 = '0;

        // Reset state
        #3;
        chk("rst_ov",   32'(out_valid), 32'h0);
        chk("rst_od",   32'(out_data),  32'h0);
        chk("rst_busy", 32'(busy),      32'h0);
        chk("rst_err",  32'(cfg_err),   32'h0);
        chk("rst_ov2",  32'(out_valid2), 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // ch0 default D=4, back-to-back 0x01..0x08
        for (int t = 0; t <= 13; t++) begin
            set_in(0, t < 8, 8'(t + 1));
            tick();
            ev = (t >= 4 && t <= 11);
            chk("t1_ov", 32'(out_valid[0]), 32'(ev));
            if (ev) chk("t1_od", od(0), 32'(t - 3));
        end
        set_in(0, 1'b0, 8'h0);

        // ch1 D=16, valid every 3rd cycle across pointer wrap
        for (int t = 0; t <= 60; t++) begin
            cfg_we = (t == 0); cfg_ch = 2'd1; cfg_delay = 5'd16;
            set_in(1, (t >= 1 && t <= 40 && (t - 1) % 3 == 0), 8'(32'hA0 + (t - 1) / 3));
            tick();
            s  = t - 16;
            ev = (s >= 1 && s <= 40 && (s - 1) % 3 == 0);
            chk("t2_ov", 32'(out_valid[1]), 32'(ev));
            if (ev) chk("t2_od", od(1), 32'hA0 + 32'((s - 1) / 3));
            chk("t2_busy", 32'(busy[1]), 32'(t < 16));
            if (t == 0) chk("t2_err", 32'(cfg_err), 32'h0);
        end
        cfg_we = 1'b0;
        set_in(1, 1'b0, 8'h0);

        // ch2 D=4 streaming, reprogrammed to D=2 at t=8; ch0 streams alongside
        for (int t = 0; t <= 24; t++) begin
            cfg_we = (t == 8); cfg_ch = 2'd2; cfg_delay = 5'd2;
            set_in(0, t <= 19, 8'(32'h50 + t));
            set_in(2, t <= 19, 8'(32'h30 + t));
            tick();
            ev = (t >= 4 && t <= 23);
            chk("t3_ov0", 32'(out_valid[0]), 32'(ev));
            if (ev) chk("t3_od0", od(0), 32'(32'h50 + t - 4));
            if (t < 8) begin
                ev = (t >= 4);
                chk("t3_ov2", 32'(out_valid[2]), 32'(ev));
                if (ev) chk("t3_od2", od(2), 32'(32'h30 + t - 4));
            end else if (t < 10) begin
                chk("t3_ov2_flush", 32'(out_valid[2]), 32'h0);
            end else begin
                ev = (t <= 21);
                chk("t3_ov2", 32'(out_valid[2]), 32'(ev));
                if (ev) chk("t3_od2", od(2), 32'(32'h30 + t - 2));
            end
            chk("t3_busy", 32'(busy), 32'((t == 8 || t == 9) ? 4'b0100 : 4'b0000));
            chk("t3_ov13", 32'({out_valid[3], out_valid[1]}), 32'h0);
            chk("t3_err", 32'(cfg_err), 32'h0);
        end
        cfg_we = 1'b0; in_valid = '0;

        // cfg_delay=0 clamps to 1; sample on the cfg edge uses D=1
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_delay = 5'd0; set_in(0, 1'b1, 8'h66);
        tick();
        chk("t4a_err",  32'(cfg_err),      32'h1);
        chk("t4a_busy", 32'(busy[0]),      32'h1);
        chk("t4a_ov",   32'(out_valid[0]), 32'h0);
        cfg_we = 1'b0; set_in(0, 1'b0, 8'h0);
        tick();
        chk("t4a_err_clr", 32'(cfg_err),      32'h0);
        chk("t4a_busy_clr", 32'(busy[0]),     32'h0);
        chk("t4a_ov1",     32'(out_valid[0]), 32'h1);
        chk("t4a_od1",     od(0),             32'h66);
        tick();
        chk("t4a_ov_end",  32'(out_valid[0]), 32'h0);

        // cfg_delay=20 clamps to 16
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_delay = 5'd20; set_in(0, 1'b1, 8'h99);
        tick();
        chk("t4b_err", 32'(cfg_err), 32'h1);
        cfg_we = 1'b0; set_in(0, 1'b0, 8'h0);
        for (int t = 1; t <= 17; t++) begin
            tick();
            chk("t4b_ov",   32'(out_valid[0]), 32'(t == 16));
            chk("t4b_busy", 32'(busy[0]),      32'(t < 16));
            if (t == 16) chk("t4b_od", od(0), 32'h99);
            if (t == 1) chk("t4b_err_clr", 32'(cfg_err), 32'h0);
        end

        // cfg_ch out of range on the 3-channel instance: flagged, no state change
        cfg_we2 = 1'b1; cfg_ch2 = 2'd3; cfg_delay2 = 3'd1;
        in_valid2[0] = 1'b1; in_data2[7:0] = 8'h5A;
        tick();
        chk("t4c_err",  32'(cfg_err2), 32'h1);
        chk("t4c_busy", 32'(busy2),    32'h0);
        cfg_we2 = 1'b0; in_valid2 = '0; in_data2 = '0;
        tick();
        chk("t4c_err_clr", 32'(cfg_err2),      32'h0);
        chk("t4c_ov_d1",   32'(out_valid2[0]), 32'h0);
        tick();
        chk("t4c_ov_d2",   32'(out_valid2[0]), 32'h1);
        chk("t4c_od_d2",   32'(out_data2[7:0]), 32'h5A);

        // ch3: D=8 then D=3 on consecutive edges, sample on the second edge
        for (int t = 0; t <= 8; t++) begin
            cfg_we = (t <= 1); cfg_ch = 2'd3; cfg_delay = (t == 0) ? 5'd8 : 5'd3;
            set_in(3, t == 1, 8'hC3);
            tick();
            chk("t5_busy", 32'(busy[3]),      32'(t <= 3));
            chk("t5_ov",   32'(out_valid[3]), 32'(t == 4));
            if (t == 4) chk("t5_od", od(3), 32'hC3);
        end
        cfg_we = 1'b0; set_in(3, 1'b0, 8'h0);

        // Asynchronous reset mid-stream (ch0 D=16 and ch2 D=2 carrying data)
        for (int t = 0; t <= 5; t++) begin
            set_in(0, 1'b1, 8'(32'hE0 + t));
            set_in(2, 1'b1, 8'(32'hF0 + t));
            tick();
            chk("t6_pre_ov2", 32'(out_valid[2]), 32'(t >= 2));
        end
        in_valid = '0;
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("t6_rst_ov",   32'(out_valid), 32'h0);
        chk("t6_rst_od",   32'(out_data),  32'h0);
        chk("t6_rst_busy", 32'(busy),      32'h0);
        @(posedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        for (int t = 0; t < 20; t++) begin
            tick();
            chk("t6_no_stale", 32'(out_valid), 32'h0);
        end
        set_in(0, 1'b1, 8'h11);
        set_in(3, 1'b1, 8'h33);
        for (int t = 0; t <= 6; t++) begin
            tick();
            in_valid = '0;
            chk("t6_ov0", 32'(out_valid[0]), 32'(t == 4));
            chk("t6_ov3", 32'(out_valid[3]), 32'(t == 4));
            chk("t6_ov2", 32'(out_valid[2]), 32'h0);
            if (t == 4) begin
                chk("t6_od0", od(0), 32'h11);
                chk("t6_od3", od(3), 32'h33);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
